reaction_timer: RTL and testbench

- Downstream consumer of the LED-sequence FSM and LFSR random delay in the reaction-time game.
- Arms when a round starts and flags a false start if the player presses before the LEDs go dark.
- Once the LEDs go dark (delay time_out), counts milliseconds in BCD until the player presses; then holds the result and the session best for the 7-segment display driver.

---
 rtl/reaction_timer_pkg.sv | 27 ++
 rtl/reaction_timer_if.sv | 25 ++
 rtl/reaction_timer_bcd_digit_counter.sv | 29 ++
 rtl/reaction_timer.sv | 117 +++++++++++
 tb/tb_reaction_timer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-time game timer.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE
    } state_t;

    localparam int unsigned BCD_MAX_DIGIT = 9;
    localparam int unsigned MAX_DIGITS    = 16;

    // Packed BCD vector with the lowest ndigits nibbles set to 9.
    // Callers cast the result down to 4*NDIGITS bits.
    function automatic logic [4*MAX_DIGITS-1:0] all_nines(input int unsigned ndigits);
        logic [4*MAX_DIGITS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < ndigits) begin
                v[4*i +: 4] = 4'(BCD_MAX_DIGIT);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Round-control inputs and result outputs of the reaction timer.
interface reaction_timer_if #(
    parameter int unsigned NDIGITS = 4
);
    logic                   start;
    logic                   go;
    logic                   tick_ms;
    logic                   press;
    logic [4*NDIGITS-1:0]   result_bcd;
    logic [4*NDIGITS-1:0]   best_bcd;
    logic                   busy;
    logic                   done;
    logic                   early;
    logic                   overflow;

    modport master (
        output start, go, tick_ms, press,
        input  result_bcd, best_bcd, busy, done, early, overflow
    );

    modport slave (
        input  start, go, tick_ms, press,
        output result_bcd, best_bcd, busy, done, early, overflow
    );
endinterface

// File: rtl/reaction_timer_bcd_digit_counter.sv
// One BCD digit: synchronous clear, increment with 9->0 wrap and carry out.
module bcd_digit_counter
    import reaction_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry_out
);

    // Carry ripples combinationally so a whole chain advances in one cycle.
    always_comb begin
        carry_out = inc & (digit == 4'(BCD_MAX_DIGIT));
    end

    // Digit register: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == 4'(BCD_MAX_DIGIT)) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on start, detects false starts, counts ms in BCD
// after go, and holds the latest result plus the session best.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
)(
    input  logic            clk,
    input  logic            rst_n,
    reaction_timer_if.slave bus
);

    localparam int unsigned     W         = 4 * NDIGITS;
    localparam logic [W-1:0]    ALL_NINES = W'(all_nines(NDIGITS));

    state_t             state;
    logic               press_q;
    logic               press_edge;
    logic [W-1:0]       count;
    logic [NDIGITS:0]   carry;
    logic               cnt_clr;

    // Key edge register: only a fresh press counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= bus.press;
        end
    end

    // Counter control. The top carry doubles as the saturation detector:
    // it fires exactly on a tick while the count is all 9s.
    always_comb begin
        press_edge = bus.press & ~press_q;
        cnt_clr    = bus.start | ((state == ARMED) & bus.go);
        carry[0]   = (state == TIMING) & bus.tick_ms & ~press_edge & ~bus.start;
    end

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (cnt_clr),
            .inc       (carry[i]),
            .digit     (count[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    // Round FSM with registered outputs; start overrides go and press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.result_bcd <= '0;
            bus.best_bcd   <= ALL_NINES;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.early      <= 1'b0;
            bus.overflow   <= 1'b0;
        end else if (bus.start) begin
            state          <= ARMED;
            bus.result_bcd <= '0;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.early      <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                ARMED: begin
                    if (press_edge) begin
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.result_bcd <= '0;
                        if (bus.go) begin
                            // Zero-time reaction: valid, beats any nonzero best.
                            if (bus.best_bcd != '0) begin
                                bus.best_bcd <= '0;
                            end
                        end else begin
                            bus.early <= 1'b1;
                        end
                    end else if (bus.go) begin
                        state <= TIMING;
                    end
                end
                TIMING: begin
                    if (press_edge) begin
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.result_bcd <= count;
                        // MSD-first packing makes the binary compare a BCD compare.
                        if (count < bus.best_bcd) begin
                            bus.best_bcd <= count;
                        end
                    end else if (carry[NDIGITS]) begin
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.overflow   <= 1'b1;
                        bus.result_bcd <= ALL_NINES;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with hand-computed expected values.
module tb_reaction_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reaction_timer_if #(.NDIGITS(4)) bus ();

    reaction_timer #(.NDIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_ms = 1'b1;
            @(negedge clk);
            bus.tick_ms = 1'b0;
        end
    endtask

    task automatic do_press();
        bus.press = 1'b1;
        @(negedge clk);
        bus.press = 1'b0;
    endtask

    task automatic run_round(input int n);
        pulse_start();
        pulse_go();
        tick_n(n);
        do_press();
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.go      = 1'b0;
        bus.tick_ms = 1'b0;
        bus.press   = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_result", 32'(bus.result_bcd), 32'h0000);
        check("rst_best",   32'(bus.best_bcd),   32'h9999);
        check("rst_busy",   32'(bus.busy),       32'h0);
        check("rst_done",   32'(bus.done),       32'h0);
        check("rst_early",  32'(bus.early),      32'h0);
        check("rst_ovf",    32'(bus.overflow),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal round
        pulse_start();
        check("armed_busy", 32'(bus.busy), 32'h1);
        pulse_go();
        tick_n(237);
        check("timing_busy", 32'(bus.busy), 32'h1);
        check("timing_done", 32'(bus.done), 32'h0);
        do_press();
        check("norm_result", 32'(bus.result_bcd), 32'h0237);
        check("norm_done",   32'(bus.done),       32'h1);
        check("norm_busy",   32'(bus.busy),       32'h0);
        check("norm_early",  32'(bus.early),      32'h0);
        check("norm_best",   32'(bus.best_bcd),   32'h0237);

        // False start, then a stray go while in DONE
        pulse_start();
        do_press();
        check("fs_done",   32'(bus.done),       32'h1);
        check("fs_early",  32'(bus.early),      32'h1);
        check("fs_result", 32'(bus.result_bcd), 32'h0000);
        check("fs_best",   32'(bus.best_bcd),   32'h0237);
        pulse_go();
        tick_n(3);
        check("fs_go_busy", 32'(bus.busy), 32'h0);
        check("fs_go_done", 32'(bus.done), 32'h1);

        // Overflow: 9999 ticks reach all 9s, the next one saturates
        pulse_start();
        pulse_go();
        tick_n(9999);
        check("pre_ovf_busy", 32'(bus.busy), 32'h1);
        tick_n(1);
        check("ovf_done",   32'(bus.done),       32'h1);
        check("ovf_flag",   32'(bus.overflow),   32'h1);
        check("ovf_result", 32'(bus.result_bcd), 32'h9999);
        check("ovf_best",   32'(bus.best_bcd),   32'h0237);
        do_press();
        check("ovf_press_result", 32'(bus.result_bcd), 32'h9999);
        check("ovf_press_done",   32'(bus.done),       32'h1);

        // Fresh session for best tracking
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_round(310);
        check("b1_result", 32'(bus.result_bcd), 32'h0310);
        check("b1_best",   32'(bus.best_bcd),   32'h0310);
        run_round(195);
        check("b2_best",   32'(bus.best_bcd),   32'h0195);
        run_round(250);
        check("b3_result", 32'(bus.result_bcd), 32'h0250);
        check("b3_best",   32'(bus.best_bcd),   32'h0195);
        run_round(195);
        check("b4_result", 32'(bus.result_bcd), 32'h0195);
        check("b4_best",   32'(bus.best_bcd),   32'h0195);

        // Tick and press in the same cycle at count 41
        pulse_start();
        pulse_go();
        tick_n(41);
        bus.tick_ms = 1'b1;
        bus.press   = 1'b1;
        @(negedge clk);
        bus.tick_ms = 1'b0;
        bus.press   = 1'b0;
        check("tp_result", 32'(bus.result_bcd), 32'h0041);
        check("tp_best",   32'(bus.best_bcd),   32'h0041);

        // Abort mid-TIMING at count 120
        pulse_start();
        pulse_go();
        tick_n(120);
        pulse_start();
        check("ab_busy",   32'(bus.busy),       32'h1);
        check("ab_done",   32'(bus.done),       32'h0);
        check("ab_result", 32'(bus.result_bcd), 32'h0000);
        check("ab_best",   32'(bus.best_bcd),   32'h0041);
        do_press();
        check("ab_fs_early", 32'(bus.early), 32'h1);

        // go and press edge in the same cycle
        pulse_start();
        bus.go    = 1'b1;
        bus.press = 1'b1;
        @(negedge clk);
        bus.go    = 1'b0;
        bus.press = 1'b0;
        check("gp_result", 32'(bus.result_bcd), 32'h0000);
        check("gp_early",  32'(bus.early),      32'h0);
        check("gp_done",   32'(bus.done),       32'h1);
        check("gp_best",   32'(bus.best_bcd),   32'h0000);

        // Key held across start and go: no edge until release and re-press
        bus.press = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        pulse_go();
        tick_n(5);
        check("hold_busy",  32'(bus.busy),  32'h1);
        check("hold_early", 32'(bus.early), 32'h0);
        bus.press = 1'b0;
        @(negedge clk);
        do_press();
        check("hold_result", 32'(bus.result_bcd), 32'h0005);
        check("hold_done",   32'(bus.done),       32'h1);

        // Asynchronous reset mid-TIMING, observed before the next rising edge
        pulse_start();
        pulse_go();
        tick_n(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",   32'(bus.busy),       32'h0);
        check("ar_done",   32'(bus.done),       32'h0);
        check("ar_result", 32'(bus.result_bcd), 32'h0000);
        check("ar_best",   32'(bus.best_bcd),   32'h9999);
        check("ar_early",  32'(bus.early),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick_n(4);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
